// File: rtl/debounce_ms.sv
// Button debouncer driven by a 1-clock millisecond tick: 2-FF synchronizer, 4-state
// acceptance FSM, registered level and press/release strobes. Optional AUTOREPEAT_EN adds held-key repeat.
module debounce_ms #(
  parameter int STABLE_TICKS = 20,
  parameter int CNT_W        = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [1:0] S_LOW     = 2'd0;
  localparam logic [1:0] S_WAIT_HI = 2'd1;
  localparam logic [1:0] S_HIGH    = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 1);

  if (STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      STABLE_TICKS > 2**CNT_W || REPEAT_DELAY > 2**CNT_W || REPEAT_RATE > 2**CNT_W) begin : g_bad_params
    $error("debounce_ms: tick parameters out of range for CNT_W");
  end

  logic             sync_p0;
  logic             sync_p1;
  logic             s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rpt_fire;

  // Synchronizer stage boundary: btn_in -> sync_p0 -> sync_p1
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  assign s = sync_p1;

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] rpt_cnt;
  logic [CNT_W-1:0] rpt_last;
  logic             rpt_armed;

  // After the first repeat the interval switches from the initial delay to the rate.
  assign rpt_last = rpt_armed ? RATE_LAST : DELAY_LAST;
  assign rpt_fire = (state == S_HIGH) && s && tick && (rpt_cnt == rpt_last);

  always_ff @(posedge clk) begin
    if (reset || state != S_HIGH) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (s && tick) begin
      if (rpt_cnt == rpt_last) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // State stage boundary: s/tick -> state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOW;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        S_LOW: begin
          if (s) begin
            state <= S_WAIT_HI;
            cnt   <= '0;
          end
        end
        S_WAIT_HI: begin
          // A bounce back wins over a coincident tick.
          if (!s) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state     <= S_HIGH;
              cnt       <= '0;
              btn_level <= 1'b1;
              btn_press <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (!s) begin
            state <= S_WAIT_LO;
            cnt   <= '0;
          end else if (rpt_fire) begin
            btn_press <= 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (s) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state       <= S_LOW;
              cnt         <= '0;
              btn_level   <= 1'b0;
              btn_release <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_ms.sv
// Bench for debounce_ms: directed scenarios plus randomized bouncing, checked every clock
// against a model that counts ticks the synchronized input spends disagreeing with the accepted level.
module tb_debounce_ms;

  localparam int ST = 4;
  localparam int RD = 8;
  localparam int RR = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  int n_press = 0;
  int n_rel = 0;

  // reference model state
  logic sq0 = 1'b0;
  logic sq1 = 1'b0;
  logic lvl = 1'b0;
  logic pend = 1'b0;
  int   nt = 0;
  int   held = 0;
  logic exp_press = 1'b0;
  logic exp_rel = 1'b0;

  debounce_ms #(
    .STABLE_TICKS(ST),
    .CNT_W(10),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp_v);
    end
  endtask

  // Model update for one clock edge, using the inputs that were stable before it.
  task automatic model_edge();
    logic sv;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    if (reset) begin
      sq0 = 1'b0; sq1 = 1'b0; lvl = 1'b0; pend = 1'b0; nt = 0; held = 0;
    end else begin
      sv  = sq1;
      sq1 = sq0;
      sq0 = btn_in;
      if (sv != lvl) begin
        if (!pend) begin
          pend = 1'b1;
          nt   = 0;
        end else if (tick) begin
          nt++;
          if (nt == ST) begin
            lvl  = sv;
            pend = 1'b0;
            held = 0;
            if (sv) exp_press = 1'b1;
            else    exp_rel   = 1'b1;
          end
        end
      end else if (pend) begin
        pend = 1'b0;
        held = 0;
      end else if (lvl && tick) begin
        held++;
`ifdef AUTOREPEAT_EN
        if (held == RD || (held > RD && (held - RD) % RR == 0)) exp_press = 1'b1;
`endif
      end
    end
  endtask

  task automatic step_t(input logic b, input logic t);
    btn_in = b;
    tick   = t;
    @(posedge clk);
    model_edge();
    #1;
    chk("level", int'(btn_level), int'(lvl));
    chk("press", int'(btn_press), int'(exp_press));
    chk("release", int'(btn_release), int'(exp_rel));
    if (btn_press) n_press++;
    if (btn_release) n_rel++;
  endtask

  task automatic step(input logic b);
    logic t;
    t = (phase == 0);
    phase = (phase == 4) ? 0 : phase + 1;
    step_t(b, t);
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  initial begin
    // 1: reset held 3 clocks with the button pressed, then the clock after it
    reset = 1'b1;
    hold(1'b1, 3);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(btn_press), 0);
    reset = 1'b0;
    step(1'b1);
    chk("post_rst_level", int'(btn_level), 0);
    chk("post_rst_release", int'(btn_release), 0);
    hold(1'b0, 10);

    // 2: clean press
    n_press = 0; n_rel = 0;
    hold(1'b1, 40);
    chk("clean_presses", n_press, 1);
    chk("clean_releases", n_rel, 0);
    chk("clean_level", int'(btn_level), 1);
    hold(1'b0, 40);

    // 3: bouncing every 7 clocks, then settle high
    n_press = 0; n_rel = 0;
    for (int k = 0; k < 60; k++) step(((k / 7) % 2) == 0);
    chk("bounce_strobes", n_press + n_rel, 0);
    hold(1'b1, 40);
    chk("settle_presses", n_press, 1);
    hold(1'b0, 40);

    // 4: press then release, 30 clocks each
    n_press = 0; n_rel = 0;
    hold(1'b1, 30);
    hold(1'b0, 30);
    chk("pr_presses", n_press, 1);
    chk("pr_releases", n_rel, 1);
    chk("pr_level", int'(btn_level), 0);

    // 5: bounce low on the same clock as a tick while waiting high
    n_press = 0; n_rel = 0;
    step_t(1'b1, 1'b0); step_t(1'b1, 1'b0); step_t(1'b1, 1'b0);
    step_t(1'b1, 1'b1);
    step_t(1'b0, 1'b0); step_t(1'b0, 1'b0); step_t(1'b0, 1'b1);
    hold(1'b0, 20);
    chk("abort_presses", n_press, 0);
    chk("abort_level", int'(btn_level), 0);

    // 6: long hold, repeat strobes when enabled
    phase = 0;
    n_press = 0; n_rel = 0;
    hold(1'b1, 127);
`ifdef AUTOREPEAT_EN
    chk("hold_presses", n_press, 6);
`else
    chk("hold_presses", n_press, 1);
`endif
    hold(1'b0, 40);
    chk("hold_releases", n_rel, 1);

    // randomized bouncing, tick patterns and occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      logic b;
      int len;
      int mode;
      b    = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 35);
      mode = $urandom_range(0, 3);
      reset = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < len; i++) begin
        if (i == 2) reset = 1'b0;
        case (mode)
          0:       step_t(b, 1'b1);
          1:       step_t(b, ($urandom_range(0, 2) == 0));
          default: step(b);
        endcase
      end
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
